// File: rtl/cascade_downcounter.sv
// Two-stage cascaded down-counting timer: prescaler underflow enables the main counter.
// Define CASCADE_DOWNCOUNTER_AUTO_RELOAD_EN for periodic operation instead of one-shot.
module cascade_downcounter #(
   parameter int unsigned PRE_WIDTH = 4,
   parameter int unsigned CNT_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [PRE_WIDTH-1:0] pre_val,
   input  logic [CNT_WIDTH-1:0] cnt_val,
   input  logic                 start,
   input  logic                 stop,
   output logic                 busy,
   output logic                 tick,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 done,
   output logic                 expired
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam logic [PRE_WIDTH-1:0] PRE_ONE = PRE_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               state, state_nx;
   logic [PRE_WIDTH-1:0] pre_cnt, pre_cnt_nx;
   logic [CNT_WIDTH-1:0] cnt, cnt_nx;
   logic [PRE_WIDTH-1:0] pre_reload, pre_reload_nx;
   logic [CNT_WIDTH-1:0] cnt_reload, cnt_reload_nx;
   logic [PRE_WIDTH-1:0] pre_start;
   logic [CNT_WIDTH-1:0] cnt_start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pre_cnt    <= '0;
         cnt        <= '0;
         pre_reload <= '1;
         cnt_reload <= '1;
      end else begin
         state      <= state_nx;
         pre_cnt    <= pre_cnt_nx;
         cnt        <= cnt_nx;
         pre_reload <= pre_reload_nx;
         cnt_reload <= cnt_reload_nx;
      end
   end

   // A load on the same edge as start is bypassed straight into the counters.
   assign pre_start = load ? pre_val : pre_reload;
   assign cnt_start = load ? cnt_val : cnt_reload;

   always_comb begin
      state_nx      = state;
      pre_cnt_nx    = pre_cnt;
      cnt_nx        = cnt;
      pre_reload_nx = pre_reload;
      cnt_reload_nx = cnt_reload;
      unique case (state)
         IDLE, EXPIRED: begin
            if (load) begin
               pre_reload_nx = pre_val;
               cnt_reload_nx = cnt_val;
            end
            if (start) begin
               pre_cnt_nx = pre_start;
               cnt_nx     = cnt_start;
               state_nx   = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_nx = IDLE;
            end else if (pre_cnt != '0) begin
               pre_cnt_nx = pre_cnt - PRE_ONE;
            end else begin
               pre_cnt_nx = pre_reload;
               if (cnt != '0) begin
                  cnt_nx = cnt - CNT_ONE;
               end else begin
`ifdef CASCADE_DOWNCOUNTER_AUTO_RELOAD_EN
                  cnt_nx = cnt_reload;
`else
                  state_nx = EXPIRED;
`endif
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy    = (state == RUN);
   assign expired = (state == EXPIRED);
   assign tick    = busy && (pre_cnt == '0) && !stop;
   assign done    = tick && (cnt == '0);
   assign count   = cnt;

endmodule

// File: tb/tb_cascade_downcounter.sv
// Directed self-checking bench for cascade_downcounter (default parameters).
// Cycle k is the clock period following edge k-1, where start is sampled at edge 0.
module tb_cascade_downcounter;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [3:0] pre_val;
   logic [2:0] cnt_val;
   logic       start;
   logic       stop;
   logic       busy;
   logic       tick;
   logic [2:0] count;
   logic       done;
   logic       expired;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   cascade_downcounter #(.PRE_WIDTH(4), .CNT_WIDTH(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .pre_val (pre_val),
      .cnt_val (cnt_val),
      .start   (start),
      .stop    (stop),
      .busy    (busy),
      .tick    (tick),
      .count   (count),
      .done    (done),
      .expired (expired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Checks cycles k_from..k_to of a countdown started with reload values p, c.
   task automatic run_cycles(input int k_from, input int k_to, input int p, input int c);
      for (int k = k_from; k <= k_to; k++) begin
         int exp_cnt;
         int exp_tick;
         #1;
         exp_cnt  = c - (((k - 1) / (p + 1)) % (c + 1));
         exp_tick = ((k % (p + 1)) == 0) ? 1 : 0;
         check($sformatf("busy_c%0d", k), busy, 1);
         check($sformatf("tick_c%0d", k), tick, exp_tick);
         check($sformatf("count_c%0d", k), count, exp_cnt);
         check($sformatf("done_c%0d", k), done, (exp_tick == 1 && exp_cnt == 0) ? 1 : 0);
         check($sformatf("expired_c%0d", k), expired, 0);
         next_cycle();
      end
   endtask

   task automatic begin_run(input logic do_load, input int p, input int c);
      load    = do_load;
      pre_val = 4'(p);
      cnt_val = 3'(c);
      start   = 1'b1;
      next_cycle();
      load  = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; pre_val = '0; cnt_val = '0; start = 1'b0; stop = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_tick", tick, 0);
      check("rst_done", done, 0);
      check("rst_expired", expired, 0);
      check("rst_count", count, 0);
      next_cycle();

`ifndef CASCADE_DOWNCOUNTER_AUTO_RELOAD_EN
      // P=15 C=7 loaded separately, then started
      load = 1'b1; pre_val = 4'd15; cnt_val = 3'd7;
      next_cycle();
      load = 1'b0;
      begin_run(1'b0, 15, 7);
      run_cycles(1, 128, 15, 7);
      #1;
      check("t1_expired", expired, 1);
      check("t1_busy", busy, 0);
      check("t1_count", count, 0);
      check("t1_tick", tick, 0);
      next_cycle();

      // P=0 C=0 with load and start on the same edge, from EXPIRED
      begin_run(1'b1, 0, 0);
      #1;
      check("t2_tick", tick, 1);
      check("t2_done", done, 1);
      check("t2_busy", busy, 1);
      next_cycle();
      check("t2_expired", expired, 1);
      check("t2_busy_after", busy, 0);
`endif

      // P=3 C=5, stop in cycle 10
      begin_run(1'b1, 3, 5);
      run_cycles(1, 9, 3, 5);
      stop = 1'b1;
      #1;
      check("t3_stop_tick", tick, 0);
      check("t3_stop_done", done, 0);
      next_cycle();
      stop = 1'b0;
      for (int k = 11; k <= 16; k++) begin
         #1;
         check($sformatf("t3_busy_c%0d", k), busy, 0);
         check($sformatf("t3_expired_c%0d", k), expired, 0);
         check($sformatf("t3_count_c%0d", k), count, 3);
         check($sformatf("t3_done_c%0d", k), done, 0);
         next_cycle();
      end

`ifndef CASCADE_DOWNCOUNTER_AUTO_RELOAD_EN
      // P=3 C=1, stop exactly on the terminal cycle 8
      begin_run(1'b1, 3, 1);
      run_cycles(1, 7, 3, 1);
      stop = 1'b1;
      #1;
      check("t4_tick", tick, 0);
      check("t4_done", done, 0);
      next_cycle();
      stop = 1'b0;
      #1;
      check("t4_busy", busy, 0);
      check("t4_expired", expired, 0);
      check("t4_count", count, 0);
      next_cycle();

      // P=2 C=2, load during RUN ignored
      begin_run(1'b1, 2, 2);
      run_cycles(1, 1, 2, 2);
      load = 1'b1; pre_val = 4'd0; cnt_val = 3'd0;
      run_cycles(2, 2, 2, 2);
      load = 1'b0;
      run_cycles(3, 9, 2, 2);
      #1;
      check("t5_expired", expired, 1);
      next_cycle();
      begin_run(1'b0, 0, 0);
      run_cycles(1, 9, 2, 2);
      #1;
      check("t5_expired2", expired, 1);
      next_cycle();
      begin_run(1'b0, 0, 0);
      run_cycles(1, 3, 2, 2);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_tick", tick, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_expired", expired, 0);
      check("t5_rst_count", count, 0);
      next_cycle();

      // start and stop together in IDLE: start wins, reload is back to all ones
      stop = 1'b1;
      begin_run(1'b0, 0, 0);
      stop = 1'b0;
      run_cycles(1, 20, 15, 7);
`else
      // periodic: P=1 C=1 gives done every 4 cycles until stop
      begin_run(1'b1, 1, 1);
      run_cycles(1, 14, 1, 1);
      stop = 1'b1;
      #1;
      check("ar_stop_done", done, 0);
      next_cycle();
      stop = 1'b0;
      #1;
      check("ar_busy", busy, 0);
      check("ar_expired", expired, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
